// File: rtl/rggen_bit_field_set_arbiter_pkg.sv
// Shared definitions for bit field controllers: controller state encoding and
// an index-width helper.
package rggen_bit_field_set_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Number of index bits needed to address 'count' items, never less than 1.
    function automatic int clog2_min1(input int count);
        int width;
        width = 1;
        while ((1 << width) < count) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/rggen_bit_field_set_arbiter_picker.sv
// Combinational round-robin picker: masked priority search starting at the
// pointer, falling back to a plain lowest-index search when nothing is above it.
module rggen_round_robin_picker
    import rggen_bit_field_set_arbiter_pkg::*;
#(
    parameter int REQUESTERS  = 2,
    parameter int INDEX_WIDTH = clog2_min1(REQUESTERS)
)(
    input  logic [REQUESTERS-1:0]  i_request,
    input  logic [INDEX_WIDTH-1:0] i_pointer,
    output logic [REQUESTERS-1:0]  o_winner,
    output logic [INDEX_WIDTH-1:0] o_index
);

    logic [REQUESTERS-1:0] masked;
    logic                  found;

    always_comb begin
        masked   = '0;
        o_winner = '0;
        o_index  = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < REQUESTERS; i++) begin
            masked[i] = i_request[i] && (INDEX_WIDTH'(i) >= i_pointer);
        end
        for (int unsigned i = 0; i < REQUESTERS; i++) begin
            if (!found && masked[i]) begin
                found       = 1'b1;
                o_winner[i] = 1'b1;
                o_index     = INDEX_WIDTH'(i);
            end
        end
        for (int unsigned i = 0; i < REQUESTERS; i++) begin
            if (!found && i_request[i]) begin
                found       = 1'b1;
                o_winner[i] = 1'b1;
                o_index     = INDEX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/rggen_bit_field_set_arbiter.sv
// Round-robin arbiter sharing one RWS bit field's hardware set path.
// Optional bounded retry: define RGGEN_BIT_FIELD_SET_ARBITER_RETRY_LIMIT_EN.
module rggen_bit_field_set_arbiter
    import rggen_bit_field_set_arbiter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int REQUESTERS  = 2,
    parameter int WRITE_FIRST = 1,
    parameter int RETRY_LIMIT = 4
)(
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [REQUESTERS-1:0]         i_request,
    input  logic [REQUESTERS*WIDTH-1:0]   i_request_value,
    input  logic                          i_sw_write,
    output logic                          o_set,
    output logic [WIDTH-1:0]              o_value,
    output logic [REQUESTERS-1:0]         o_grant,
    output logic [REQUESTERS-1:0]         o_drop,
    output logic                          o_busy
);

    localparam int INDEX_WIDTH = clog2_min1(REQUESTERS);

    if ((REQUESTERS < 1) || (REQUESTERS > 16) || (RETRY_LIMIT < 1) || (RETRY_LIMIT > 255)) begin : g_param_check
        $error("rggen_bit_field_set_arbiter: REQUESTERS or RETRY_LIMIT out of range");
    end

    state_t                 state;
    logic [INDEX_WIDTH-1:0] rr_pointer;
    logic [INDEX_WIDTH-1:0] winner_index;
    logic [INDEX_WIDTH-1:0] next_pointer;
    logic [REQUESTERS-1:0]  pick_winner;
    logic [INDEX_WIDTH-1:0] pick_index;
    logic [WIDTH-1:0]       pick_value;
    logic                   blocked;
    logic                   accept;
    logic                   abandon;

    rggen_round_robin_picker #(
        .REQUESTERS  (REQUESTERS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_picker (
        .i_request (i_request),
        .i_pointer (rr_pointer),
        .o_winner  (pick_winner),
        .o_index   (pick_index)
    );

    always_comb begin
        pick_value = '0;
        for (int unsigned k = 0; k < REQUESTERS; k++) begin
            if (pick_winner[k]) begin
                pick_value = pick_value | i_request_value[k*WIDTH +: WIDTH];
            end
        end
    end

    assign blocked      = (WRITE_FIRST != 0) && i_sw_write;
    assign accept       = (state == ISSUE) && !blocked;
    assign next_pointer = (winner_index == INDEX_WIDTH'(REQUESTERS - 1))
                        ? '0 : winner_index + INDEX_WIDTH'(1);

`ifdef RGGEN_BIT_FIELD_SET_ARBITER_RETRY_LIMIT_EN
    logic [7:0] retry_count;

    // Abandon only once the limit is reached and this attempt is blocked too.
    assign abandon = (state == ISSUE) && blocked && (retry_count == 8'(RETRY_LIMIT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            retry_count <= '0;
        end else if (state == ISSUE) begin
            retry_count <= (accept || abandon) ? '0 : retry_count + 8'd1;
        end
    end

    always_comb begin
        o_drop = '0;
        for (int unsigned k = 0; k < REQUESTERS; k++) begin
            o_drop[k] = abandon && (winner_index == INDEX_WIDTH'(k));
        end
    end
`else
    assign abandon = 1'b0;
    assign o_drop  = '0;
`endif

    always_comb begin
        o_grant = '0;
        for (int unsigned k = 0; k < REQUESTERS; k++) begin
            o_grant[k] = accept && (winner_index == INDEX_WIDTH'(k));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            o_set        <= 1'b0;
            o_value      <= '0;
            o_busy       <= 1'b0;
            rr_pointer   <= '0;
            winner_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|i_request) begin
                        winner_index <= pick_index;
                        o_value      <= pick_value;
                        o_set        <= 1'b1;
                        o_busy       <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (accept || abandon) begin
                        o_set      <= 1'b0;
                        o_busy     <= 1'b0;
                        rr_pointer <= next_pointer;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rggen_bit_field_set_arbiter.sv
// Self-checking bench: WRITE_FIRST=1 and WRITE_FIRST=0 instances driven in parallel,
// checked every cycle against a behavioural model plus directed literal checks.
module tb_rggen_bit_field_set_arbiter;

`ifdef RGGEN_BIT_FIELD_SET_ARBITER_RETRY_LIMIT_EN
    localparam bit LIM_EN = 1'b1;
`else
    localparam bit LIM_EN = 1'b0;
`endif
    localparam int LIMIT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [15:0] rval;
    logic        sw;

    logic        set_w   [2];
    logic [7:0]  value_w [2];
    logic [1:0]  grant_w [2];
    logic [1:0]  drop_w  [2];
    logic        busy_w  [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rggen_bit_field_set_arbiter #(
        .WIDTH(8), .REQUESTERS(2), .WRITE_FIRST(1), .RETRY_LIMIT(LIMIT)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_request(req), .i_request_value(rval),
        .i_sw_write(sw), .o_set(set_w[0]), .o_value(value_w[0]),
        .o_grant(grant_w[0]), .o_drop(drop_w[0]), .o_busy(busy_w[0])
    );

    rggen_bit_field_set_arbiter #(
        .WIDTH(8), .REQUESTERS(2), .WRITE_FIRST(0), .RETRY_LIMIT(LIMIT)
    ) dut_wf0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_request(req), .i_request_value(rval),
        .i_sw_write(sw), .o_set(set_w[1]), .o_value(value_w[1]),
        .o_grant(grant_w[1]), .o_drop(drop_w[1]), .o_busy(busy_w[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: index 0 is WRITE_FIRST=1, index 1 is WRITE_FIRST=0.
    int         m_busy [2];
    int         m_win  [2];
    int         m_ptr  [2];
    int         m_cnt  [2];
    logic [7:0] m_val  [2];

    always @(negedge clk) begin
        logic       blk;
        logic       drp;
        logic [1:0] eg;
        logic [1:0] ed;
        for (int j = 0; j < 2; j++) begin
            if (!rst_n) begin
                m_busy[j] = 0; m_win[j] = 0; m_ptr[j] = 0; m_cnt[j] = 0; m_val[j] = 8'h00;
            end
            blk = (j == 0) && sw;
            drp = (m_busy[j] != 0) && blk && LIM_EN && (m_cnt[j] == LIMIT);
            eg  = ((m_busy[j] != 0) && !blk) ? 2'(1 << m_win[j]) : 2'b00;
            ed  = drp ? 2'(1 << m_win[j]) : 2'b00;
            chk($sformatf("model_set[%0d]", j),   32'(set_w[j]),   32'(m_busy[j] != 0));
            chk($sformatf("model_busy[%0d]", j),  32'(busy_w[j]),  32'(m_busy[j] != 0));
            chk($sformatf("model_value[%0d]", j), 32'(value_w[j]), 32'(m_val[j]));
            chk($sformatf("model_grant[%0d]", j), 32'(grant_w[j]), 32'(eg));
            chk($sformatf("model_drop[%0d]", j),  32'(drop_w[j]),  32'(ed));
            if (rst_n) begin
                if (m_busy[j] == 0) begin
                    for (int d = 0; d < 2; d++) begin
                        int k;
                        k = (m_ptr[j] + d) % 2;
                        if (m_busy[j] == 0 && req[k]) begin
                            m_busy[j] = 1;
                            m_win[j]  = k;
                            m_val[j]  = rval[k*8 +: 8];
                            m_cnt[j]  = 0;
                        end
                    end
                end else if (!blk || drp) begin
                    m_busy[j] = 0;
                    m_ptr[j]  = (m_win[j] + 1) % 2;
                    m_cnt[j]  = 0;
                end else begin
                    m_cnt[j] = m_cnt[j] + 1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = 2'b00; rval = 16'h0000; sw = 1'b0;
        repeat (3) cyc();
        #1;
        for (int j = 0; j < 2; j++) begin
            chk("reset_set",   32'(set_w[j]),   32'h0);
            chk("reset_value", 32'(value_w[j]), 32'h0);
            chk("reset_grant", 32'(grant_w[j]), 32'h0);
            chk("reset_drop",  32'(drop_w[j]),  32'h0);
            chk("reset_busy",  32'(busy_w[j]),  32'h0);
        end
        rst_n = 1'b1;

        cyc(); req = 2'b01; rval = 16'h005A;
        cyc(); #1;
        chk("single_set",   32'(set_w[0]),   32'h1);
        chk("single_value", 32'(value_w[0]), 32'h5A);
        chk("single_grant", 32'(grant_w[0]), 32'h1);
        cyc(); req = 2'b00; #1;
        chk("single_set_low", 32'(set_w[0]),   32'h0);
        chk("single_no_grant", 32'(grant_w[0]), 32'h0);
        cyc();

        reset_pulse(); req = 2'b11; rval = 16'h2211;
        cyc(); #1;
        chk("fair1_value", 32'(value_w[0]), 32'h11);
        chk("fair1_grant", 32'(grant_w[0]), 32'h1);
        cyc(); #1;
        chk("fair_gap1", 32'(set_w[0]), 32'h0);
        cyc(); #1;
        chk("fair2_value", 32'(value_w[0]), 32'h22);
        chk("fair2_grant", 32'(grant_w[0]), 32'h2);
        cyc(); #1;
        chk("fair_gap2", 32'(set_w[0]), 32'h0);
        cyc(); #1;
        chk("fair3_value", 32'(value_w[0]), 32'h11);
        chk("fair3_grant", 32'(grant_w[0]), 32'h1);
        cyc(); req = 2'b00;
        cyc();

        reset_pulse(); req = 2'b01; rval = 16'h003C;
        cyc(); sw = 1'b1; #1;
        chk("coll1_set",     32'(set_w[0]),   32'h1);
        chk("coll1_grant",   32'(grant_w[0]), 32'h0);
        chk("coll_wf0_grant", 32'(grant_w[1]), 32'h1);
        cyc(); rval = 16'h00C3; #1;
        chk("coll2_set",   32'(set_w[0]),   32'h1);
        chk("coll2_value", 32'(value_w[0]), 32'h3C);
        chk("coll2_grant", 32'(grant_w[0]), 32'h0);
        cyc(); sw = 1'b0; #1;
        chk("coll3_set",   32'(set_w[0]),   32'h1);
        chk("coll3_value", 32'(value_w[0]), 32'h3C);
        chk("coll3_grant", 32'(grant_w[0]), 32'h1);
        cyc(); req = 2'b00; #1;
        chk("coll_end_set", 32'(set_w[0]), 32'h0);
        cyc();

`ifdef RGGEN_BIT_FIELD_SET_ARBITER_RETRY_LIMIT_EN
        reset_pulse(); req = 2'b11; rval = 16'h2211; sw = 1'b1;
        cyc(); #1;
        chk("lim1_drop", 32'(drop_w[0]), 32'h0);
        cyc(); #1;
        chk("lim2_drop", 32'(drop_w[0]), 32'h0);
        cyc(); #1;
        chk("lim3_drop",  32'(drop_w[0]),  32'h1);
        chk("lim3_grant", 32'(grant_w[0]), 32'h0);
        cyc(); sw = 1'b0; #1;
        chk("lim_idle_set", 32'(set_w[0]), 32'h0);
        cyc(); #1;
        chk("lim_next_value", 32'(value_w[0]), 32'h22);
        chk("lim_next_grant", 32'(grant_w[0]), 32'h2);
        cyc(); req = 2'b00;
        cyc();
`endif

        reset_pulse(); req = 2'b01; rval = 16'h00A5; sw = 1'b1;
        cyc(); #1;
        chk("mid_set_before", 32'(set_w[0]), 32'h1);
        rst_n = 1'b0; #1;
        chk("mid_set_abort", 32'(set_w[0]),   32'h0);
        chk("mid_no_grant",  32'(grant_w[0]), 32'h0);
        chk("mid_busy",      32'(busy_w[0]),  32'h0);
        sw = 1'b0;
        cyc(); rst_n = 1'b1;
        cyc(); #1;
        chk("mid_reissue_set",   32'(set_w[0]),   32'h1);
        chk("mid_reissue_value", 32'(value_w[0]), 32'hA5);
        chk("mid_reissue_grant", 32'(grant_w[0]), 32'h1);
        cyc(); req = 2'b00;
        cyc();

        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst_n = ($urandom_range(0, 199) != 0);
            req   = 2'($urandom_range(0, 3));
            rval  = 16'($urandom);
            sw    = ($urandom_range(0, 1) == 1);
        end
        cyc(); rst_n = 1'b1; req = 2'b00; sw = 1'b0;
        repeat (4) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
